rca_seq_ctrl: RTL

Sequencer that adds two WIDTH-bit operands through one shared 4-bit ripple-carry slice, one nibble per clock, least significant first. The inter-nibble carry is registered between cycles. Operands enter through a valid/ready request handshake, and the result leaves through a valid/ready response handshake. The block replaces a wide combinational adder where area matters more than latency.

---
 rtl/rca_seq_pkg.sv | 15 +
 rtl/rca_seq_ctrl_add4_slice.sv | 30 +++
 rtl/rca_seq_ctrl.sv | 120 ++++++++++++
 3 files changed

// File: rtl/rca_seq_pkg.sv
// Shared types and constants for the sequential ripple-carry adder.
//   state_t  : controller state encoding (IDLE, RUN, DONE)
//   NIB_BITS : width of the shared adder slice; operands are consumed
//              this many bits per clock
package rca_seq_pkg;

  localparam int NIB_BITS = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/rca_seq_ctrl_add4_slice.sv
// add4_slice: combinational 4-bit ripple-carry adder built from per-bit
// full adders.
//   a, b : nibble operands
//   ci   : carry in
//   s    : nibble sum
//   co   : carry out of bit 3
module add4_slice
  import rca_seq_pkg::*;
(
  input  logic [NIB_BITS-1:0] a,
  input  logic [NIB_BITS-1:0] b,
  input  logic                ci,
  output logic [NIB_BITS-1:0] s,
  output logic                co
);

  logic [NIB_BITS:0] c;

  assign c[0] = ci;

  generate
    for (genvar gi = 0; gi < NIB_BITS; gi++) begin : g_fa
      assign s[gi]   = a[gi] ^ b[gi] ^ c[gi];
      assign c[gi+1] = (a[gi] & b[gi]) | (c[gi] & (a[gi] ^ b[gi]));
    end
  endgenerate

  assign co = c[NIB_BITS];

endmodule

// File: rtl/rca_seq_ctrl.sv
// rca_seq_ctrl: adds two WIDTH-bit operands through one shared 4-bit
// ripple-carry slice, one nibble per clock, least significant nibble first.
// The carry between nibbles is held in a register.
//
// Optional feature: define RCA_SEQ_SUB_EN to add the op port
// (0 = add, 1 = subtract a-b via inverted b and forced carry-in).
//
// Ports:
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   start_valid/start_ready  request handshake; a, b, cin (and op) captured
//                            on accept
//   res_valid/res_ready      response handshake
//   sum, cout                result and carry out of the top nibble; they
//                            change only while running
//   busy                     high while an operation is in flight or held
module rca_seq_ctrl
  import rca_seq_pkg::*;
#(
  parameter  int WIDTH = 16,
  localparam int NIB   = WIDTH / NIB_BITS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef RCA_SEQ_SUB_EN
  input  logic             op,
`endif
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;

  state_t                       state_reg, state_next;
  logic [IDX_W-1:0]             idx_reg;
  logic [NIB-1:0][NIB_BITS-1:0] a_reg, b_reg, sum_reg;
  logic                         carry_reg, cout_reg, start_ready_reg;
  logic                         accept, last_nib;
  logic [NIB_BITS-1:0]          slice_s;
  logic                         slice_co;

  // start_ready is registered so it stays low for the cycle after reset
  // releases and has no path from any input.
  assign accept   = start_valid && start_ready_reg;
  assign last_nib = (idx_reg == IDX_W'(NIB - 1));

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept)    state_next = RUN;
      RUN:     if (last_nib)  state_next = DONE;
      DONE:    if (res_ready) state_next = IDLE;
      default:                state_next = IDLE;
    endcase
  end

  add4_slice u_slice (
    .a  (a_reg[idx_reg]),
    .b  (b_reg[idx_reg]),
    .ci (carry_reg),
    .s  (slice_s),
    .co (slice_co)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_reg         <= '0;
      carry_reg       <= 1'b0;
      cout_reg        <= 1'b0;
      sum_reg         <= '0;
      a_reg           <= '0;
      b_reg           <= '0;
      start_ready_reg <= 1'b0;
    end else begin
      start_ready_reg <= (state_next == IDLE);
      case (state_reg)
        IDLE: begin
          if (accept) begin
            a_reg   <= a;
            idx_reg <= '0;
`ifdef RCA_SEQ_SUB_EN
            // a - b = a + ~b + 1
            b_reg     <= op ? ~b : b;
            carry_reg <= op ? 1'b1 : cin;
`else
            b_reg     <= b;
            carry_reg <= cin;
`endif
          end
        end
        RUN: begin
          sum_reg[idx_reg] <= slice_s;
          carry_reg        <= slice_co;
          if (last_nib) cout_reg <= slice_co;
          else          idx_reg  <= idx_reg + IDX_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign start_ready = start_ready_reg;
  assign res_valid   = (state_reg == DONE);
  assign busy        = (state_reg != IDLE);
  assign sum         = sum_reg;
  assign cout        = cout_reg;

endmodule
